// File: rtl/bcd_down_timer.sv
// 4-digit BCD countdown timer with preset, start/stop/load control and completion flag.
// Latency: RUN is entered 1 cycle after start; first decrement PRESCALE cycles later. Outputs registered.
// No backpressure; control pulses sampled every cycle, priority load > stop > start. Option: BCD_DONE_HOLD_EN.
module bcd_down_timer #(
    parameter int PRESCALE = 1,
    parameter int WRAP     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    input  logic [3:0] din2,
    input  logic [3:0] din3,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] out0,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
    localparam bit          WRAP_EN = (WRAP != 0);

`ifdef BCD_DONE_HOLD_EN
    localparam bit DONE_HOLD = 1'b1;
`else
    localparam bit DONE_HOLD = 1'b0;
`endif

    logic [1:0]  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] preset, preset_nxt;
    logic [15:0] pre, pre_nxt;
    logic        done_q, done_nxt;

    logic [15:0] din_clamped;
    logic [15:0] cnt_dec;
    logic        cnt_zero;
    logic        preset_zero;
    logic        start_ok;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Whole-word BCD decrement; the borrow ripples through all digits in one cycle.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [15:0] r;
        logic        borrow;
        r      = c;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (c[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = c[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign din_clamped = {clamp9(din3), clamp9(din2), clamp9(din1), clamp9(din0)};
    assign cnt_dec     = bcd_dec(cnt);
    assign cnt_zero    = (cnt == 16'h0000);
    assign preset_zero = (preset == 16'h0000);
    assign start_ok    = !cnt_zero && !(WRAP_EN && preset_zero);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        preset_nxt = preset;
        pre_nxt    = pre;
        done_nxt   = DONE_HOLD ? done_q : 1'b0;

        if (load) begin
            cnt_nxt    = din_clamped;
            preset_nxt = din_clamped;
            pre_nxt    = 16'd0;
            state_nxt  = S_IDLE;
            done_nxt   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!stop && start && start_ok) begin
                        state_nxt = S_RUN;
                        pre_nxt   = 16'd0;
                        done_nxt  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_nxt = S_PAUSE;
                    end else if (pre == PS_LAST) begin
                        pre_nxt = 16'd0;
                        // Only a wrapping timer can still be running at 0000: reload instead of decrementing.
                        if (cnt_zero) begin
                            if (WRAP_EN) begin
                                cnt_nxt = preset;
                            end else begin
                                state_nxt = S_IDLE;
                            end
                        end else begin
                            cnt_nxt = cnt_dec;
                            if (cnt_dec == 16'h0000) begin
                                done_nxt = 1'b1;
                                if (!WRAP_EN) begin
                                    state_nxt = S_IDLE;
                                end
                            end
                        end
                    end else begin
                        pre_nxt = pre + 16'd1;
                    end
                end
                S_PAUSE: begin
                    if (!stop && start) begin
                        state_nxt = S_RUN;
                        done_nxt  = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= 16'h0000;
            preset <= 16'h0000;
            pre    <= 16'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            preset <= preset_nxt;
            pre    <= pre_nxt;
            done_q <= done_nxt;
        end
    end

    assign out0 = cnt[3:0];
    assign out1 = cnt[7:4];
    assign out2 = cnt[11:8];
    assign out3 = cnt[15:12];
    assign busy = (state == S_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: three instances (PRESCALE=1, PRESCALE=4, WRAP=1) share stimulus.
module tb_bcd_down_timer;

`ifdef BCD_DONE_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       load, start, stop;
    logic [3:0] din0, din1, din2, din3;

    logic [3:0] a0, a1, a2, a3;
    logic       a_busy, a_done;
    logic [3:0] b0, b1, b2, b3;
    logic       b_busy, b_done;
    logic [3:0] w0, w1, w2, w3;
    logic       w_busy, w_done;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int          inst;
        logic [17:0] v;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    bcd_down_timer #(.PRESCALE(1), .WRAP(0)) u_p1 (
        .clk(clk), .rst(rst), .load(load),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .start(start), .stop(stop),
        .out0(a0), .out1(a1), .out2(a2), .out3(a3),
        .busy(a_busy), .done(a_done)
    );

    bcd_down_timer #(.PRESCALE(4), .WRAP(0)) u_p4 (
        .clk(clk), .rst(rst), .load(load),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .start(start), .stop(stop),
        .out0(b0), .out1(b1), .out2(b2), .out3(b3),
        .busy(b_busy), .done(b_done)
    );

    bcd_down_timer #(.PRESCALE(1), .WRAP(1)) u_wr (
        .clk(clk), .rst(rst), .load(load),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .start(start), .stop(stop),
        .out0(w0), .out1(w1), .out2(w2), .out3(w3),
        .busy(w_busy), .done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] outs(input int inst);
        case (inst)
            0:       return {a3, a2, a1, a0, a_busy, a_done};
            1:       return {b3, b2, b1, b0, b_busy, b_done};
            default: return {w3, w2, w1, w0, w_busy, w_done};
        endcase
    endfunction

    task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got count=%h busy=%b done=%b, expected count=%h busy=%b done=%b",
                     nm, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // Applies one cycle of inputs; the expected post-edge outputs go to the scoreboard.
    task automatic step(input logic l, input logic s, input logic p, input logic [15:0] d,
                        input int inst, input logic [15:0] ec, input logic eb, input logic ed,
                        input string nm);
        exp_t e;
        @(negedge clk);
        load  = l;
        start = s;
        stop  = p;
        {din3, din2, din1, din0} = d;
        if (inst >= 0) begin
            e.inst = inst;
            e.v    = {ec, eb, ed};
            e.nm   = nm;
            exp_q.push_back(e);
        end
    endtask

    function automatic logic [15:0] bcd(input int v);
        return {8'h00, 4'(v / 10), 4'(v % 10)};
    endfunction

    // Monitor: compares the registered outputs just after each edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.nm, outs(e.inst), e.v);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        {din3, din2, din1, din0} = 16'h0000;
        #1 rst = 1'b0;
        #2;
        check("reset_p1", outs(0), 18'h0);
        check("reset_p4", outs(1), 18'h0);
        check("reset_wr", outs(2), 18'h0);
        @(negedge clk);
        rst = 1'b1;

        // Basic countdown from 0012
        step(1, 0, 0, 16'h0012, 0, 16'h0012, 1'b0, 1'b0, "load12");
        step(0, 1, 0, 16'h0000, 0, 16'h0012, 1'b1, 1'b0, "start12");
        for (int v = 11; v >= 0; v--)
            step(0, 0, 0, 16'h0000, 0, bcd(v), (v != 0), (v == 0), "count12");
        step(0, 0, 0, 16'h0000, 0, 16'h0000, 1'b0, HOLD, "after_done");
        step(0, 1, 0, 16'h0000, 0, 16'h0000, 1'b0, HOLD, "restart_at_zero");

        // Borrow chain, load during RUN, clamp, zero preset
        step(1, 0, 0, 16'h1000, 0, 16'h1000, 1'b0, 1'b0, "load1000");
        step(0, 1, 0, 16'h0000, 0, 16'h1000, 1'b1, 1'b0, "start1000");
        step(0, 0, 0, 16'h0000, 0, 16'h0999, 1'b1, 1'b0, "borrow1000");
        step(1, 0, 0, 16'h0100, 0, 16'h0100, 1'b0, 1'b0, "load0100_in_run");
        step(0, 1, 0, 16'h0000, 0, 16'h0100, 1'b1, 1'b0, "start0100");
        step(0, 0, 0, 16'h0000, 0, 16'h0099, 1'b1, 1'b0, "borrow0100");
        step(1, 0, 0, 16'h00FC, 0, 16'h0099, 1'b0, 1'b0, "clamp");
        step(1, 0, 0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, "load0000");
        step(0, 1, 0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, "start_zero");

        // PRESCALE=4: pause mid-period, priority, resume
        step(1, 0, 0, 16'h0005, 1, 16'h0005, 1'b0, 1'b0, "p4_load");
        step(0, 1, 0, 16'h0000, 1, 16'h0005, 1'b1, 1'b0, "p4_start");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 16'h0000, 1, 16'h0005, 1'b1, 1'b0, "p4_wait");
        step(0, 0, 0, 16'h0000, 1, 16'h0004, 1'b1, 1'b0, "p4_tick1");
        step(0, 0, 0, 16'h0000, 1, 16'h0004, 1'b1, 1'b0, "p4_run1");
        step(0, 0, 0, 16'h0000, 1, 16'h0004, 1'b1, 1'b0, "p4_run2");
        step(0, 0, 1, 16'h0000, 1, 16'h0004, 1'b0, 1'b0, "p4_stop");
        for (int i = 0; i < 9; i++)
            step(0, 0, 0, 16'h0000, 1, 16'h0004, 1'b0, 1'b0, "p4_paused");
        step(0, 1, 1, 16'h0000, 1, 16'h0004, 1'b0, 1'b0, "p4_start_stop");
        step(0, 1, 0, 16'h0000, 1, 16'h0004, 1'b1, 1'b0, "p4_resume");
        step(0, 0, 0, 16'h0000, 1, 16'h0004, 1'b1, 1'b0, "p4_resume_wait");
        step(0, 0, 0, 16'h0000, 1, 16'h0003, 1'b1, 1'b0, "p4_resume_tick");
        step(1, 1, 0, 16'h0042, 1, 16'h0042, 1'b0, 1'b0, "p4_load_in_run");

        // WRAP=1: reload from preset, busy throughout
        step(1, 0, 0, 16'h0002, 2, 16'h0002, 1'b0, 1'b0, "w_load");
        step(0, 1, 0, 16'h0000, 2, 16'h0002, 1'b1, 1'b0, "w_start");
        step(0, 0, 0, 16'h0000, 2, 16'h0001, 1'b1, 1'b0, "w_1a");
        step(0, 0, 0, 16'h0000, 2, 16'h0000, 1'b1, 1'b1, "w_0a");
        step(0, 0, 0, 16'h0000, 2, 16'h0002, 1'b1, HOLD, "w_reload");
        step(0, 0, 0, 16'h0000, 2, 16'h0001, 1'b1, HOLD, "w_1b");
        step(0, 0, 0, 16'h0000, 2, 16'h0000, 1'b1, 1'b1, "w_0b");
        step(0, 0, 0, 16'h0000, 2, 16'h0002, 1'b1, HOLD, "w_reload2");
        step(1, 0, 0, 16'h0000, 2, 16'h0000, 1'b0, 1'b0, "w_load0");
        step(0, 1, 0, 16'h0000, 2, 16'h0000, 1'b0, 1'b0, "w_start_zero");

        // Asynchronous reset mid-count at 0420
        step(1, 0, 0, 16'h0420, 1, 16'h0420, 1'b0, 1'b0, "r_load");
        step(0, 1, 0, 16'h0000, 1, 16'h0420, 1'b1, 1'b0, "r_start");
        step(0, 0, 0, 16'h0000, 1, 16'h0420, 1'b1, 1'b0, "r_run");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_p4", outs(1), 18'h0);
        check("async_reset_p1", outs(0), 18'h0);
        check("async_reset_wr", outs(2), 18'h0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 0, 16'h0000, 1, 16'h0000, 1'b0, 1'b0, "preset_lost");
        step(0, 0, 0, 16'h0000, -1, 16'h0000, 1'b0, 1'b0, "idle");

        repeat (3) @(negedge clk);
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
